// File: rtl/memory_requester_pkg.sv
// Shared constants for the memory requester: default geometry, FSM state
// encodings and the client identifier used by the arbiter.
package memory_requester_pkg;

  localparam int DEF_MEMORY_ADDRESS_SIZE    = 32;
  localparam int DEF_CACHE_LINE_SIZE        = 128;
  localparam int DEF_MEMORY_OP_DELAY_CYCLES = 5;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ACTIVE     = 2'd1;
  localparam logic [1:0] WAIT_READY = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;

  typedef enum logic {
    CLIENT_IC = 1'b0,
    CLIENT_DC = 1'b1
  } client_t;

endpackage

// File: rtl/memory_request_arbiter.sv
// Two-way round-robin arbiter: req[0] is the icache, req[1] the dcache.
// On a tie the client that did not win last time is granted.
module memory_request_arbiter
  import memory_requester_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  client_t r_lastGrant;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (r_lastGrant == CLIENT_IC) ? 2'b10 : 2'b01;
    end
  end

  // Reset favours the dcache on the first tie by recording the icache as last winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastGrant <= CLIENT_IC;
    end else if (update && (grant != 2'b00)) begin
      r_lastGrant <= grant[1] ? CLIENT_DC : CLIENT_IC;
    end
  end

endmodule

// File: rtl/memory_requester.sv
// Initiator side of the line-transfer protocol: arbitrates icache/dcache line
// requests and runs one Memory transaction at a time with registered outputs.
module memory_requester
  import memory_requester_pkg::*;
#(
  parameter int MEMORY_ADDRESS_SIZE    = DEF_MEMORY_ADDRESS_SIZE,
  parameter int CACHE_LINE_SIZE        = DEF_CACHE_LINE_SIZE,
  parameter int MEMORY_OP_DELAY_CYCLES = DEF_MEMORY_OP_DELAY_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ic_req,
  input  logic [MEMORY_ADDRESS_SIZE-1:0] ic_addr,
  output logic                           ic_ready,
  output logic [CACHE_LINE_SIZE-1:0]     ic_data,
  input  logic                           dc_req,
  input  logic                           dc_op,
  input  logic [MEMORY_ADDRESS_SIZE-1:0] dc_addr,
  input  logic [CACHE_LINE_SIZE-1:0]     dc_wdata,
  output logic                           dc_ready,
  output logic [CACHE_LINE_SIZE-1:0]     dc_rdata,
  output logic                           mem_enable,
  output logic                           mem_op,
  output logic [MEMORY_ADDRESS_SIZE-1:0] mem_address,
  output logic [CACHE_LINE_SIZE-1:0]     mem_data_in,
  output logic                           mem_op_init,
  output logic                           mem_op_done,
  input  logic [CACHE_LINE_SIZE-1:0]     mem_data_out,
  input  logic                           mem_data_ready,
  output logic                           busy
);

  localparam int OFFSET_BITS = $clog2(CACHE_LINE_SIZE / 8);
  localparam int CNT_W       = $clog2(MEMORY_OP_DELAY_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEMORY_OP_DELAY_CYCLES + 1);
  localparam logic [MEMORY_ADDRESS_SIZE-1:0] LOW_MASK =
    MEMORY_ADDRESS_SIZE'((64'd1 << OFFSET_BITS) - 64'd1);

  logic [1:0]                     r_state;
  client_t                        r_client;
  logic [CNT_W-1:0]               r_cnt;
  logic [1:0]                     w_req;
  logic [1:0]                     w_grant;
  logic                           w_accept;
  logic [MEMORY_ADDRESS_SIZE-1:0] w_reqAddr;
  logic [MEMORY_ADDRESS_SIZE-1:0] w_alignedAddr;

  assign w_req         = {dc_req, ic_req};
  assign w_accept      = (r_state == IDLE) && (w_grant != 2'b00) && !mem_data_ready;
  assign w_reqAddr     = w_grant[1] ? dc_addr : ic_addr;
  assign w_alignedAddr = w_reqAddr & ~LOW_MASK;

  memory_request_arbiter u_arbiter (
    .clk    (clk),
    .reset  (reset),
    .req    (w_req),
    .update (w_accept),
    .grant  (w_grant)
  );

  // One transaction per pass: IDLE -> ACTIVE (enable window) -> WAIT_READY -> DONE.
  // The enable window closes at the same edge Memory raises data_ready, so
  // enable is never high while data_ready is.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_client    <= CLIENT_IC;
      r_cnt       <= '0;
      ic_ready    <= 1'b0;
      ic_data     <= '0;
      dc_ready    <= 1'b0;
      dc_rdata    <= '0;
      mem_enable  <= 1'b0;
      mem_op      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_op_init <= 1'b0;
      mem_op_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state     <= ACTIVE;
            r_client    <= w_grant[1] ? CLIENT_DC : CLIENT_IC;
            r_cnt       <= '0;
            mem_op      <= w_grant[1] ? dc_op : 1'b0;
            mem_address <= w_alignedAddr;
            mem_data_in <= w_grant[1] ? dc_wdata : '0;
            mem_enable  <= 1'b1;
            mem_op_init <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ACTIVE: begin
          mem_op_init <= 1'b0;
          if (r_cnt == CNT_LAST) begin
            mem_enable <= 1'b0;
            r_state    <= WAIT_READY;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_READY: begin
          if (mem_data_ready) begin
            mem_op_done <= 1'b1;
            r_state     <= DONE;
            if (r_client == CLIENT_IC) begin
              ic_data  <= mem_data_out;
              ic_ready <= 1'b1;
            end else begin
              if (!mem_op) begin
                dc_rdata <= mem_data_out;
              end
              dc_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          mem_op_done <= 1'b0;
          ic_ready    <= 1'b0;
          dc_ready    <= 1'b0;
          busy        <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
